// File: rtl/ysyx_24110015_icache_pkg.sv
// Shared types and AXI constants for the direct-mapped instruction cache.
// Contents: icache_state_e (controller states), AXI burst/size/response
// encodings and the fixed AR id used for every refill.
package ysyx_24110015_icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_AR     = 3'd2,
    S_R      = 3'd3,
    S_RESP   = 3'd4
  } icache_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [3:0] AXI_ID_IFU     = 4'd0;

endpackage

// File: rtl/ysyx_24110015_icache_array.sv
// Tag/data/valid storage for the instruction cache.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears valid bits only)
//   idx             : line index shared by reads and writes (single outstanding miss)
//   rd_word         : word select for the asynchronous data read
//   rd_data/rd_tag/rd_valid : asynchronous read of the selected line
//   data_we, wr_word, wr_data : single-word write into line idx
//   line_we, line_valid, wr_tag : close a refill; tag is written only when the
//                                 line becomes valid, otherwise the line is invalidated
//   flush           : invalidate every line
module ysyx_24110015_icache_array
  import ysyx_24110015_icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_LINES)-1:0]  idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic [31:0]                   rd_data,
  output logic [TAG_W-1:0]              rd_tag,
  output logic                          rd_valid,
  input  logic                          data_we,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          line_we,
  input  logic                          line_valid,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          flush
);

  logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  assign rd_data  = data_mem[idx][rd_word];
  assign rd_tag   = tag_mem[idx];
  assign rd_valid = valid_q[idx];

  // Valid bits: the only reset state in the cache.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= line_valid;
    end
  end

  // Data words, no reset.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[idx][wr_word] <= wr_data;
    end
  end

  // Tags, no reset.
  always_ff @(posedge clk) begin
    if (line_we && line_valid) begin
      tag_mem[idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/ysyx_24110015_icache.sv
// Direct-mapped read-only instruction cache between the IFU fetch port and
// the IFU-side AXI master. Hits answer one cycle after acceptance; misses
// refill the whole line with one INCR burst and then answer.
// Optional build macro: ICACHE_PERF_EN adds saturating perf counters
//   (perf_hit, perf_miss, perf_refill), cleared by reset and by flush.
// Ports:
//   clk, rst                               : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr           : fetch request
//   rsp_valid/rsp_ready/rsp_inst/rsp_err   : fetch response
//   flush_valid/flush_ready                : invalidate-all (fence.i)
//   arvalid/arready/araddr/arid/arlen/arsize/arburst : AXI read address
//   rvalid/rready/rdata/rresp/rlast        : AXI read data
module ysyx_24110015_icache
  import ysyx_24110015_icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        flush_valid,
  output logic        flush_ready,
`ifdef ICACHE_PERF_EN
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss,
  output logic [31:0] perf_refill,
`endif
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;

  icache_state_e state_q, state_d;

  // pc_q holds addr[31:2]; the byte offset of an aligned fetch carries no information.
  logic [29:0]       pc_q, pc_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic [TAG_W-1:0]  tag_f;
  logic [IDX_W-1:0]  idx_f;
  logic [WORD_W-1:0] word_f;

  logic [31:0]       rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit;
  logic              beat_err;
  logic              data_we;
  logic              line_we;
  logic              line_valid;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  assign tag_f  = pc_q[29 -: TAG_W];
  assign idx_f  = pc_q[WORD_W +: IDX_W];
  assign word_f = pc_q[0 +: WORD_W];

  assign hit      = rd_valid && (rd_tag == tag_f);
  assign beat_err = (rresp != RESP_OKAY);

  assign arid    = AXI_ID_IFU;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  ysyx_24110015_icache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx_f),
    .rd_word    (word_f),
    .rd_data    (rd_data),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .data_we    (data_we),
    .wr_word    (beat_q),
    .wr_data    (rdata),
    .line_we    (line_we),
    .line_valid (line_valid),
    .wr_tag     (tag_f),
    .flush      (flush_ready)
  );

  // State and request-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshake outputs and array write controls.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    beat_d      = beat_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    flush_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_inst    = '0;
    rsp_err     = 1'b0;
    arvalid     = 1'b0;
    araddr      = '0;
    rready      = 1'b0;
    data_we     = 1'b0;
    line_we     = 1'b0;
    line_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A pending flush wins over a new request.
        if (flush_valid) begin
          flush_ready = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            pc_d    = req_addr[31:2];
            state_d = S_LOOKUP;
          end
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          rsp_inst  = rd_data;
          if (rsp_ready) begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_AR;
        end
      end

      S_AR: begin
        arvalid = 1'b1;
        araddr  = {pc_q[29 -: TAG_W + IDX_W], {OFF_W{1'b0}}};
        if (arready) begin
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_R;
        end
      end

      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          data_we = 1'b1;
          beat_d  = beat_q + WORD_W'(1);
          err_d   = err_q | beat_err;
          if (rlast) begin
            // Line becomes valid only for a clean burst of full length.
            line_we    = 1'b1;
            line_valid = !(err_q | beat_err) &&
                         (beat_q == WORD_W'(LINE_WORDS - 1));
            state_d    = S_RESP;
          end
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_inst  = rd_data;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic hit_ev;
  logic miss_ev;
  logic refill_ev;

  assign hit_ev    = (state_q == S_LOOKUP) && hit && rsp_ready;
  assign miss_ev   = (state_q == S_LOOKUP) && !hit;
  assign refill_ev = (state_q == S_AR) || (state_q == S_R);

  // Saturating performance counters, cleared by reset and flush.
  always_ff @(posedge clk) begin
    if (rst || flush_ready) begin
      perf_hit    <= '0;
      perf_miss   <= '0;
      perf_refill <= '0;
    end else begin
      if (hit_ev && (perf_hit != '1)) begin
        perf_hit <= perf_hit + 32'd1;
      end
      if (miss_ev && (perf_miss != '1)) begin
        perf_miss <= perf_miss + 32'd1;
      end
      if (refill_ev && (perf_refill != '1)) begin
        perf_refill <= perf_refill + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24110015_icache.sv
// Directed bench for the instruction cache with a line-level cache model.
module tb_ysyx_24110015_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        flush_valid;
  logic        flush_ready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  ysyx_24110015_icache dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_inst    (rsp_inst),
    .rsp_err     (rsp_err),
    .flush_valid (flush_valid),
    .flush_ready (flush_ready),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .arid        (arid),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: 16 lines of 4 words; only validity and tag are tracked, the
  // data returned is always what the memory holds.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  logic        exp_miss;
  logic [31:0] exp_araddr;
  logic [31:0] exp_inst;
  logic        exp_err;

  bit          saw_ar;
  logic [31:0] got_araddr;
  logic [31:0] got_inst;
  logic        got_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:4] == 28'h8000001) return 32'hA0 + 32'(a[3:2]);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // Per-cycle checker of visible outputs against the model's expectation.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (arvalid) begin
        chk("ar_expected", arvalid, exp_miss);
        chk("araddr", araddr, exp_araddr);
        chk("arlen", arlen, 32'd3);
        chk("arsize", arsize, 32'd2);
        chk("arburst", arburst, 32'd1);
        chk("arid", arid, 32'd0);
      end
      if (rsp_valid) begin
        chk("rsp_inst", rsp_inst, exp_inst);
        chk("rsp_err", rsp_err, exp_err);
      end else begin
        chk("rsp_inst_idle", rsp_inst, 32'd0);
      end
    end
  end

  // One fetch; the bench plays the AXI slave for a miss.
  task automatic fetch(input logic [31:0] a, input int ar_dly, input int err_beat,
                       input int nbeats, input int r_hold, input bit flush_in_r,
                       input int rsp_stall, input bit rst_in_r);
    logic [3:0]  i;
    logic [23:0] t;
    bit          hit;
    int          cyc;
    i = a[7:4];
    t = a[31:8];
    hit        = m_valid[i] && (m_tag[i] == t);
    exp_miss   = !hit;
    exp_araddr = {a[31:4], 4'h0};
    exp_inst   = mem_rd(a);
    exp_err    = !hit && (err_beat >= 0) && (err_beat < nbeats);
    saw_ar     = 1'b0;
    got_araddr = '0;

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("lookup_rsp_valid", rsp_valid, hit);

    if (!hit) begin
      cyc = 0;
      while (!arvalid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("ar_seen", arvalid, 1);
      if (!arvalid) return;
      saw_ar     = 1'b1;
      got_araddr = araddr;
      for (int k = 0; k < ar_dly; k++) begin
        @(negedge clk);
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, got_araddr);
      end
      arready = 1'b1;
      @(posedge clk);
      #1 arready = 1'b0;
      flush_valid = flush_in_r;
      for (int h = 0; h < r_hold; h++) begin
        @(negedge clk);
        chk("r_hold_rready", rready, 1);
        chk("r_flush_ready", flush_ready, 0);
        chk("r_req_ready", req_ready, 0);
      end
      if (rst_in_r) begin
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = mem_rd(exp_araddr);
        rresp  = 2'b00;
        rlast  = 1'b0;
        @(posedge clk);
        #1 rvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        exp_miss = 1'b0;
        return;
      end
      for (int b = 0; b < nbeats; b++) begin
        @(negedge clk);
        chk("beat_rready", rready, 1);
        rvalid = 1'b1;
        rdata  = mem_rd(exp_araddr + 32'(4 * b));
        rresp  = (b == err_beat) ? 2'b10 : 2'b00;
        rlast  = (b == nbeats - 1);
        @(posedge clk);
        #1 rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
      end
      @(negedge clk);
    end

    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_seen", rsp_valid, 1);
    got_inst = rsp_inst;
    got_err  = rsp_err;
    for (int s = 0; s < rsp_stall; s++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_inst", rsp_inst, got_inst);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    if (!hit) begin
      m_valid[i] = !exp_err && (nbeats == 4);
      m_tag[i]   = t;
    end
    exp_miss = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush_valid = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    exp_miss = 1'b0; exp_araddr = '0; exp_inst = '0; exp_err = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_flush_ready", flush_ready, 0);
    chk("reset_rsp_inst", rsp_inst, 0);
    chk("reset_araddr", araddr, 0);
    chk_en = 1'b1;

    // Cold miss
    fetch(32'h8000_0010, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("t1_araddr", got_araddr, 32'h8000_0010);
    chk("t1_inst", got_inst, 32'h0000_00A0);
    chk("t1_err", got_err, 0);

    // Hit on the same line
    fetch(32'h8000_001C, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("t2_inst", got_inst, 32'h0000_00A3);
    chk("t2_no_ar", saw_ar, 0);

    // Conflict on index 1
    fetch(32'h8000_0110, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("t3_araddr", got_araddr, 32'h8000_0110);
    fetch(32'h8000_0010, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("t3_remiss", saw_ar, 1);
    chk("t3_inst", got_inst, 32'h0000_00A0);

    // Error response on beat 2
    fetch(32'h8000_0020, 0, 2, 4, 0, 1'b0, 0, 1'b0);
    chk("t4_err", got_err, 1);
    fetch(32'h8000_0020, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("t4_remiss", saw_ar, 1);
    chk("t4_err_clean", got_err, 0);

    // AR backpressure, then response backpressure on a hit
    fetch(32'h8000_0030, 5, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("t5_araddr", got_araddr, 32'h8000_0030);
    fetch(32'h8000_0034, 0, -1, 4, 0, 1'b0, 3, 1'b0);
    chk("t5_hit", saw_ar, 0);
    chk("t5_inst", got_inst, 32'h40DE_0034);

    // Short burst leaves the line invalid
    fetch(32'h8000_0044, 0, -1, 2, 0, 1'b0, 0, 1'b0);
    chk("sb_inst", got_inst, 32'h40DE_0044);
    fetch(32'h8000_0044, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("sb_remiss", saw_ar, 1);

    // Flush raised during R is held off until IDLE
    fetch(32'h8000_0050, 0, -1, 4, 3, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("flush_ready_idle", flush_ready, 1);
    chk("flush_blocks_req", req_ready, 0);
    @(posedge clk);
    #1 flush_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("flush_one_cycle", flush_ready, 0);
    fetch(32'h8000_0030, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("flush_remiss", saw_ar, 1);

    // Reset in the middle of a refill
    fetch(32'h8000_0060, 0, -1, 4, 2, 1'b0, 0, 1'b1);
    fetch(32'h8000_0034, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("rst_remiss", saw_ar, 1);
    fetch(32'h8000_0038, 0, -1, 4, 0, 1'b0, 0, 1'b0);
    chk("rst_then_hit", saw_ar, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
